// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - classifies a debounced button level into press/release/short/long/double events
// Optional auto-repeat in the LONG state is enabled by defining BTN_REPEAT_EN.
module btn_event_decoder #(
    parameter int LONG_CYCLES   = 1000,
    parameter int GAP_CYCLES    = 300,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_double,
    output logic o_hold,
    output logic o_repeat
);

    localparam int MAX_AB = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
`endif
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_GAP,
        S_PRESS2,
        S_LONG
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            r_level_d;
    logic            w_rise;
    logic            w_fall;

    logic            w_press;
    logic            w_release;
    logic            w_short;
    logic            w_long;
    logic            w_double;
    logic            w_repeat;

    logic            r_press;
    logic            r_release;
    logic            r_short;
    logic            r_long;
    logic            r_double;
    logic            r_hold;
    logic            r_repeat;

    assign w_rise = i_level & ~r_level_d;
    assign w_fall = ~i_level & r_level_d;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_press      = 1'b0;
        w_release    = 1'b0;
        w_short      = 1'b0;
        w_long       = 1'b0;
        w_double     = 1'b0;
        w_repeat     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // a fall here is the held-through-reset case and is ignored
                if (w_rise) begin
                    w_next_state = S_PRESS1;
                    w_cnt_next   = CNT_ONE;
                    w_press      = 1'b1;
                end
            end
            S_PRESS1: begin
                if (i_level) begin
                    if (r_cnt == LONG_LAST) begin
                        w_next_state = S_LONG;
                        w_cnt_next   = CNT_ZERO;
                        w_long       = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_next_state = S_GAP;
                    w_cnt_next   = CNT_ONE;
                    w_release    = 1'b1;
                end
            end
            S_GAP: begin
                if (w_rise) begin
                    w_next_state = S_PRESS2;
                    w_cnt_next   = CNT_ZERO;
                    w_press      = 1'b1;
                    w_double     = 1'b1;
                end else if (!i_level) begin
                    if (r_cnt == GAP_LAST) begin
                        w_next_state = S_IDLE;
                        w_cnt_next   = CNT_ZERO;
                        w_short      = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end
            end
            S_PRESS2: begin
                if (w_fall) begin
                    w_next_state = S_IDLE;
                    w_release    = 1'b1;
                end
            end
            S_LONG: begin
                if (w_fall) begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = CNT_ZERO;
                    w_release    = 1'b1;
                end
`ifdef BTN_REPEAT_EN
                else if (r_cnt == REPEAT_LAST) begin
                    w_cnt_next = CNT_ZERO;
                    w_repeat   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
`endif
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= CNT_ZERO;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_double  <= 1'b0;
            r_hold    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_level_d <= i_level;
            r_press   <= w_press;
            r_release <= w_release;
            r_short   <= w_short;
            r_long    <= w_long;
            r_double  <= w_double;
            r_hold    <= (w_next_state == S_LONG);
            r_repeat  <= w_repeat;
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_short   = r_short;
    assign o_long    = r_long;
    assign o_double  = r_double;
    assign o_hold    = r_hold;
    assign o_repeat  = r_repeat;

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - self-checking bench for btn_event_decoder (LONG=8, GAP=4, REPEAT=3)
module tb_btn_event_decoder;

    localparam int LONG   = 8;
    localparam int GAP    = 4;
    localparam int REPEAT = 3;
`ifdef BTN_REPEAT_EN
    localparam int N_REP = 4;
`else
    localparam int N_REP = 0;
`endif

    logic clk = 1'b0;
    logic i_rst;
    logic i_level;
    logic o_press, o_release, o_short, o_long, o_double, o_hold, o_repeat;

    always #5 clk = ~clk;

    btn_event_decoder #(
        .LONG_CYCLES  (LONG),
        .GAP_CYCLES   (GAP),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_level  (i_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_short  (o_short),
        .o_long   (o_long),
        .o_double (o_double),
        .o_hold   (o_hold),
        .o_repeat (o_repeat)
    );

    typedef struct {
        int h1, l1, h2, l2;
        int n_press, n_release, n_short, n_long, n_double, n_repeat;
    } scn_t;

    scn_t scn [0:5];

    // bit order: press, release, short, long, double, hold, repeat
    logic [6:0] sb [$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cnt_ev [0:6];

    // run-length reference: counts consecutive highs/lows since the accepted edge
    logic m_prev;
    int   m_mode;   // 0 idle, 1 first press, 2 gap, 3 second press, 4 long
    int   m_hrun;
    int   m_lrun;

    task automatic model(input logic lvl, input logic rst, output logic [6:0] e);
        logic rise, fall;
        e = '0;
        if (rst) begin
            m_prev = 1'b1;
            m_mode = 0;
            m_hrun = 0;
            m_lrun = 0;
            return;
        end
        rise = lvl & ~m_prev;
        fall = ~lvl & m_prev;
        case (m_mode)
            0: if (rise) begin m_mode = 1; m_hrun = 1; e[6] = 1'b1; end
            1: if (lvl) begin
                   m_hrun++;
                   if (m_hrun == LONG) begin m_mode = 4; e[3] = 1'b1; end
               end else begin
                   m_mode = 2; m_lrun = 1; e[5] = 1'b1;
               end
            2: if (rise) begin
                   m_mode = 3; e[6] = 1'b1; e[2] = 1'b1;
               end else begin
                   m_lrun++;
                   if (m_lrun == GAP) begin m_mode = 0; e[4] = 1'b1; end
               end
            3: if (fall) begin m_mode = 0; e[5] = 1'b1; end
            default: if (fall) begin
                   m_mode = 0; e[5] = 1'b1;
               end else begin
                   m_hrun++;
`ifdef BTN_REPEAT_EN
                   if (((m_hrun - LONG) % REPEAT) == 0) e[0] = 1'b1;
`endif
               end
        endcase
        e[1] = (m_mode == 4);
        m_prev = lvl;
    endtask

    task automatic check_pending();
        logic [6:0] exp_v, act;
        if (sb.size() == 0) return;
        exp_v = sb.pop_front();
        act = {o_press, o_release, o_short, o_long, o_double, o_hold, o_repeat};
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL outputs cycle=%0d actual=%b expected=%b", cyc, act, exp_v);
        end
        total++;
        if (!$onehot0(act[4:2])) begin
            bad++;
            $display("FAIL exclusive cycle=%0d actual short/long/double=%b required at most one", cyc, act[4:2]);
        end
        for (int i = 0; i < 7; i++) if (act[6-i] === 1'b1) cnt_ev[i]++;
    endtask

    task automatic step(input logic lvl, input logic rst);
        logic [6:0] e;
        @(negedge clk);
        check_pending();
        cyc++;
        i_rst   = rst;
        i_level = lvl;
        model(lvl, rst, e);
        sb.push_back(e);
    endtask

    task automatic chk_int(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 7; i++) cnt_ev[i] = 0;
    endtask

    task automatic run_scn(input int k);
        clear_counts();
        repeat (scn[k].h1) step(1'b1, 1'b0);
        repeat (scn[k].l1) step(1'b0, 1'b0);
        repeat (scn[k].h2) step(1'b1, 1'b0);
        repeat (scn[k].l2) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_int($sformatf("scn%0d press", k),   cnt_ev[0], scn[k].n_press);
        chk_int($sformatf("scn%0d release", k), cnt_ev[1], scn[k].n_release);
        chk_int($sformatf("scn%0d short", k),   cnt_ev[2], scn[k].n_short);
        chk_int($sformatf("scn%0d long", k),    cnt_ev[3], scn[k].n_long);
        chk_int($sformatf("scn%0d double", k),  cnt_ev[4], scn[k].n_double);
        chk_int($sformatf("scn%0d repeat", k),  cnt_ev[6], scn[k].n_repeat);
    endtask

    initial begin
        //         h1  l1 h2 l2  pr rl sh lg db rep
        scn[0] = '{3,  6, 0, 0,  1, 1, 1, 0, 0, 0};
        scn[1] = '{7,  6, 0, 0,  1, 1, 1, 0, 0, 0};
        scn[2] = '{8,  6, 0, 0,  1, 1, 0, 1, 0, 0};
        scn[3] = '{2,  3, 2, 6,  2, 2, 0, 0, 1, 0};
        scn[4] = '{2,  4, 2, 6,  2, 2, 2, 0, 0, 0};
        scn[5] = '{20, 6, 0, 0,  1, 1, 0, 1, 0, N_REP};

        i_rst   = 1'b1;
        i_level = 1'b0;
        clear_counts();

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        for (int k = 0; k < 6; k++) run_scn(k);

        // button held through reset release: nothing until a fresh press
        clear_counts();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        chk_int("held-reset press", cnt_ev[0], 0);
        chk_int("held-reset release", cnt_ev[1], 0);
        chk_int("held-reset short", cnt_ev[2], 0);
        run_scn(0);

        // reset mid-press: no release afterwards, next press still decodes
        clear_counts();
        repeat (2) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        chk_int("mid-reset press", cnt_ev[0], 1);
        chk_int("mid-reset release", cnt_ev[1], 0);
        chk_int("mid-reset short", cnt_ev[2], 0);
        run_scn(3);

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
